mem_access: RTL and testbench

- Pipeline memory stage, directly downstream of the ID/EX latch and EX datapath.
- Takes a resolved EX-stage instruction, runs any data-memory read or write through a request/hit handshake with the dcache, and produces the registered MEM/WB latch contents.
- Stalls the upstream pipeline while an access is outstanding.
- Latches halt so no memory traffic is issued after a halt retires.

---
 rtl/mem_access_if.sv | 12 +
 rtl/mem_access.sv | 190 +++++++++++++++++++
 tb/tb_mem_access.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Data-cache request/hit handshake between the memory stage (master) and the dcache (slave).
interface mem_access_if;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dhit;
  logic [31:0] dload;

  modport master (output dREN, dWEN, daddr, dstore, input dhit, dload);
  modport slave  (input dREN, dWEN, daddr, dstore, output dhit, dload);
endinterface

// File: rtl/mem_access.sv
// Pipeline memory stage: issues dcache loads/stores via a request/hit handshake,
// stalls upstream while an access is outstanding, and produces the MEM/WB latch.
module mem_access #(
  parameter int TIMEOUT = 64,
  parameter int CW      = 7
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                ex_valid,
  input  logic                ex_dREN,
  input  logic                ex_dWEN,
  input  logic [31:0]         ex_addr,
  input  logic [31:0]         ex_store,
  input  logic [31:0]         ex_result,
  input  logic                ex_RegW,
  input  logic [4:0]          ex_wsel,
  input  logic                ex_halt,
  input  logic [31:0]         ex_npc,
  mem_access_if.master        dc,
  output logic                mem_stall,
  output logic                wb_valid,
  output logic                wb_RegW,
  output logic [4:0]          wb_wsel,
  output logic [31:0]         wb_wdat,
  output logic                wb_halt,
  output logic [31:0]         wb_npc,
  output logic                mem_err
);
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, HALTED = 2'd2} state_t;

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_TMO = CW'(TIMEOUT);

  state_t        state_q, state_d;
  logic          dREN_q, dREN_d, dWEN_q, dWEN_d;
  logic [31:0]   daddr_q, daddr_d, dstore_q, dstore_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hold_RegW_q, hold_RegW_d;
  logic [4:0]    hold_wsel_q, hold_wsel_d;
  logic [31:0]   hold_npc_q, hold_npc_d;
  logic          wb_valid_q, wb_valid_d, wb_RegW_q, wb_RegW_d;
  logic [4:0]    wb_wsel_q, wb_wsel_d;
  logic [31:0]   wb_wdat_q, wb_wdat_d, wb_npc_q, wb_npc_d;
  logic          wb_halt_q, wb_halt_d, mem_err_q, mem_err_d;
  logic          mem_op_s, misaligned_s, mem_stall_s;

  assign mem_op_s     = ex_valid & (ex_dREN | ex_dWEN);
  assign misaligned_s = (ex_addr[1:0] != 2'b00);

  // Next-state, request and writeback computation
  always_comb begin
    state_d     = state_q;
    dREN_d      = dREN_q;
    dWEN_d      = dWEN_q;
    daddr_d     = daddr_q;
    dstore_d    = dstore_q;
    cnt_d       = cnt_q;
    hold_RegW_d = hold_RegW_q;
    hold_wsel_d = hold_wsel_q;
    hold_npc_d  = hold_npc_q;
    wb_valid_d  = 1'b0;
    wb_RegW_d   = 1'b0;
    wb_wsel_d   = wb_wsel_q;
    wb_wdat_d   = wb_wdat_q;
    wb_npc_d    = wb_npc_q;
    wb_halt_d   = wb_halt_q;
    mem_err_d   = mem_err_q;
    mem_stall_s = 1'b0;
    case (state_q)
      IDLE: begin
        // HALT wins over any memory flags carried with it
        if (ex_valid && ex_halt) begin
          wb_valid_d = 1'b1;
          wb_RegW_d  = ex_RegW;
          wb_wsel_d  = ex_wsel;
          wb_wdat_d  = ex_result;
          wb_npc_d   = ex_npc;
          wb_halt_d  = 1'b1;
          state_d    = HALTED;
        end else if (mem_op_s && misaligned_s) begin
          mem_err_d = 1'b1;
          wb_wsel_d = ex_wsel;
          wb_wdat_d = ex_result;
          wb_npc_d  = ex_npc;
        end else if (mem_op_s) begin
          mem_stall_s = 1'b1;
          dREN_d      = ex_dREN;
          dWEN_d      = ex_dWEN & ~ex_dREN;
          daddr_d     = ex_addr;
          dstore_d    = ex_store;
          cnt_d       = {CW{1'b0}};
          hold_RegW_d = ex_RegW;
          hold_wsel_d = ex_wsel;
          hold_npc_d  = ex_npc;
          state_d     = WAIT;
        end else begin
          wb_valid_d = ex_valid;
          wb_RegW_d  = ex_valid & ex_RegW;
          wb_wsel_d  = ex_wsel;
          wb_wdat_d  = ex_result;
          wb_npc_d   = ex_npc;
        end
      end
      WAIT: begin
        mem_stall_s = 1'b1;
        if (dc.dhit) begin
          wb_valid_d = 1'b1;
          wb_RegW_d  = hold_RegW_q & dREN_q;
          wb_wsel_d  = hold_wsel_q;
          wb_wdat_d  = dREN_q ? dc.dload : 32'h0000_0000;
          wb_npc_d   = hold_npc_q;
          dREN_d     = 1'b0;
          dWEN_d     = 1'b0;
          daddr_d    = 32'h0000_0000;
          dstore_d   = 32'h0000_0000;
          state_d    = IDLE;
        end else begin
          // Timeout only flags the error; the access is never abandoned
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
          if (cnt_d == CNT_TMO) begin
            mem_err_d = 1'b1;
          end else begin
            mem_err_d = mem_err_q;
          end
        end
      end
      HALTED: begin
        mem_stall_s = 1'b1;
      end
      default: begin
        state_d = IDLE;
        dREN_d  = 1'b0;
        dWEN_d  = 1'b0;
      end
    endcase
  end

  // State and MEM/WB registers; reset abandons any request in flight
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      dREN_q      <= 1'b0;
      dWEN_q      <= 1'b0;
      daddr_q     <= 32'h0000_0000;
      dstore_q    <= 32'h0000_0000;
      cnt_q       <= {CW{1'b0}};
      hold_RegW_q <= 1'b0;
      hold_wsel_q <= 5'd0;
      hold_npc_q  <= 32'h0000_0000;
      wb_valid_q  <= 1'b0;
      wb_RegW_q   <= 1'b0;
      wb_wsel_q   <= 5'd0;
      wb_wdat_q   <= 32'h0000_0000;
      wb_npc_q    <= 32'h0000_0000;
      wb_halt_q   <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dREN_q      <= dREN_d;
      dWEN_q      <= dWEN_d;
      daddr_q     <= daddr_d;
      dstore_q    <= dstore_d;
      cnt_q       <= cnt_d;
      hold_RegW_q <= hold_RegW_d;
      hold_wsel_q <= hold_wsel_d;
      hold_npc_q  <= hold_npc_d;
      wb_valid_q  <= wb_valid_d;
      wb_RegW_q   <= wb_RegW_d;
      wb_wsel_q   <= wb_wsel_d;
      wb_wdat_q   <= wb_wdat_d;
      wb_npc_q    <= wb_npc_d;
      wb_halt_q   <= wb_halt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign dc.dREN   = dREN_q;
  assign dc.dWEN   = dWEN_q;
  assign dc.daddr  = daddr_q;
  assign dc.dstore = dstore_q;
  assign mem_stall = mem_stall_s;
  assign wb_valid  = wb_valid_q;
  assign wb_RegW   = wb_RegW_q;
  assign wb_wsel   = wb_wsel_q;
  assign wb_wdat   = wb_wdat_q;
  assign wb_halt   = wb_halt_q;
  assign wb_npc    = wb_npc_q;
  assign mem_err   = mem_err_q;
endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access (TIMEOUT shortened to 4).
module tb_mem_access;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        ex_valid, ex_dREN, ex_dWEN, ex_RegW, ex_halt;
  logic [31:0] ex_addr, ex_store, ex_result, ex_npc;
  logic [4:0]  ex_wsel;
  logic        mem_stall, wb_valid, wb_RegW, wb_halt, mem_err;
  logic [4:0]  wb_wsel;
  logic [31:0] wb_wdat, wb_npc;
  int          n_checks = 0;
  int          n_fail   = 0;

  mem_access_if dc();

  mem_access #(.TIMEOUT(4), .CW(3)) dut (
    .CLK(CLK), .nRST(nRST),
    .ex_valid(ex_valid), .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN),
    .ex_addr(ex_addr), .ex_store(ex_store), .ex_result(ex_result),
    .ex_RegW(ex_RegW), .ex_wsel(ex_wsel), .ex_halt(ex_halt), .ex_npc(ex_npc),
    .dc(dc),
    .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_RegW(wb_RegW),
    .wb_wsel(wb_wsel), .wb_wdat(wb_wdat), .wb_halt(wb_halt),
    .wb_npc(wb_npc), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  task automatic bubble();
    ex_valid = 1'b0; ex_dREN = 1'b0; ex_dWEN = 1'b0; ex_RegW = 1'b0; ex_halt = 1'b0;
    ex_addr = 32'h0; ex_store = 32'h0; ex_result = 32'h0; ex_npc = 32'h0; ex_wsel = 5'd0;
    dc.dhit = 1'b0; dc.dload = 32'h0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    bubble();
    nRST = 1'b0;
    #2;
    nRST = 1'b1;
    step();
  endtask

  task automatic test_reset();
    bubble();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++;
    if ({dc.dREN, dc.dWEN, wb_valid, wb_RegW, wb_halt, mem_err, mem_stall} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {dc.dREN, dc.dWEN, wb_valid, wb_RegW, wb_halt, mem_err, mem_stall});
    end
    n_checks++;
    if ({dc.daddr, dc.dstore, wb_wdat, wb_npc, wb_wsel} !== 133'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h %h %h expected all 0",
               dc.daddr, dc.dstore, wb_wdat, wb_npc, wb_wsel);
    end
    nRST = 1'b1;
    step();
  endtask

  task automatic test_alu();
    ex_valid = 1'b1; ex_RegW = 1'b1; ex_wsel = 5'd5; ex_result = 32'h1234; ex_npc = 32'h44;
    #1;
    n_checks++;
    if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b expected 0", mem_stall); end
    step();
    bubble();
    n_checks++;
    if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL alu_valid: got %b expected 1", wb_valid); end
    n_checks++;
    if (wb_RegW !== 1'b1) begin n_fail++; $display("FAIL alu_regw: got %b expected 1", wb_RegW); end
    n_checks++;
    if (wb_wsel !== 5'd5) begin n_fail++; $display("FAIL alu_wsel: got %0d expected 5", wb_wsel); end
    n_checks++;
    if (wb_wdat !== 32'h1234) begin n_fail++; $display("FAIL alu_wdat: got %h expected 00001234", wb_wdat); end
    n_checks++;
    if (wb_npc !== 32'h44) begin n_fail++; $display("FAIL alu_npc: got %h expected 00000044", wb_npc); end
    step();
    n_checks++;
    if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL alu_bubble: got %b expected 0", wb_valid); end
  endtask

  task automatic test_load_miss();
    int stall_n = 0;
    int addr_n  = 0;
    int valid_n = 0;
    logic [31:0] wdat_s = 32'h0;
    logic        regw_s = 1'b0;
    logic [4:0]  wsel_s = 5'd0;
    for (int c = 0; c < 8; c++) begin
      bubble();
      if (c == 0) begin
        ex_valid = 1'b1; ex_dREN = 1'b1; ex_addr = 32'h100; ex_RegW = 1'b1; ex_wsel = 5'd8;
      end
      if (c == 3) begin
        dc.dhit = 1'b1; dc.dload = 32'hCAFE_F00D;
      end
      #1;
      stall_n += int'(mem_stall);
      addr_n  += int'(dc.dREN && (dc.daddr == 32'h100));
      if (wb_valid) begin
        valid_n++; wdat_s = wb_wdat; regw_s = wb_RegW; wsel_s = wb_wsel;
      end
      step();
    end
    n_checks++;
    if (stall_n != 4) begin n_fail++; $display("FAIL load_stall_cycles: got %0d expected 4", stall_n); end
    n_checks++;
    if (addr_n != 3) begin n_fail++; $display("FAIL load_req_cycles: got %0d expected 3", addr_n); end
    n_checks++;
    if (valid_n != 1) begin n_fail++; $display("FAIL load_valid_pulses: got %0d expected 1", valid_n); end
    n_checks++;
    if (wdat_s !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL load_wdat: got %h expected cafef00d", wdat_s); end
    n_checks++;
    if (regw_s !== 1'b1) begin n_fail++; $display("FAIL load_regw: got %b expected 1", regw_s); end
    n_checks++;
    if (wsel_s !== 5'd8) begin n_fail++; $display("FAIL load_wsel: got %0d expected 8", wsel_s); end
  endtask

  task automatic test_store_hit();
    int wen_n = 0;
    for (int c = 0; c < 5; c++) begin
      bubble();
      if (c == 0) begin
        ex_valid = 1'b1; ex_dWEN = 1'b1; ex_addr = 32'h80; ex_store = 32'hDEAD;
        ex_RegW = 1'b1; ex_wsel = 5'd4;
      end
      if (c == 1 || c == 2) begin
        ex_valid = 1'b1; ex_RegW = 1'b1; ex_wsel = 5'd3; ex_result = 32'h55;
      end
      if (c == 1) dc.dhit = 1'b1;
      #1;
      wen_n += int'(dc.dWEN && (dc.dstore == 32'hDEAD) && (dc.daddr == 32'h80));
      n_checks++;
      if (dc.dREN !== 1'b0) begin n_fail++; $display("FAIL store_no_dren c%0d: got %b expected 0", c, dc.dREN); end
      if (c == 2) begin
        n_checks++;
        if ({wb_valid, wb_RegW, mem_stall} !== 3'b100) begin
          n_fail++; $display("FAIL store_retire: got %b expected 100", {wb_valid, wb_RegW, mem_stall});
        end
        n_checks++;
        if (wb_wdat !== 32'h0) begin n_fail++; $display("FAIL store_wdat: got %h expected 0", wb_wdat); end
      end
      if (c == 3) begin
        n_checks++;
        if ({wb_valid, wb_wsel, wb_wdat} !== {1'b1, 5'd3, 32'h55}) begin
          n_fail++; $display("FAIL store_next_instr: got %b/%0d/%h expected 1/3/00000055", wb_valid, wb_wsel, wb_wdat);
        end
      end
      step();
    end
    n_checks++;
    if (wen_n != 1) begin n_fail++; $display("FAIL store_req_cycles: got %0d expected 1", wen_n); end
  endtask

  task automatic test_misaligned();
    int dren_n = 0;
    ex_valid = 1'b1; ex_dREN = 1'b1; ex_addr = 32'h102; ex_RegW = 1'b1; ex_wsel = 5'd7;
    #1;
    n_checks++;
    if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL mis_stall: got %b expected 0", mem_stall); end
    step();
    bubble();
    n_checks++;
    if ({wb_valid, wb_RegW} !== 2'b00) begin n_fail++; $display("FAIL mis_bubble: got %b expected 00", {wb_valid, wb_RegW}); end
    for (int c = 0; c < 3; c++) begin
      dren_n += int'(dc.dREN);
      n_checks++;
      if (mem_err !== 1'b1) begin n_fail++; $display("FAIL mis_err c%0d: got %b expected 1", c, mem_err); end
      step();
    end
    n_checks++;
    if (dren_n != 0) begin n_fail++; $display("FAIL mis_dren: got %0d expected 0", dren_n); end
  endtask

  task automatic test_timeout();
    pulse_reset();
    n_checks++;
    if (mem_err !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got %b expected 0", mem_err); end
    for (int c = 0; c < 9; c++) begin
      bubble();
      if (c == 0) begin
        ex_valid = 1'b1; ex_dREN = 1'b1; ex_addr = 32'h200; ex_RegW = 1'b1; ex_wsel = 5'd9;
      end
      if (c == 6) begin
        dc.dhit = 1'b1; dc.dload = 32'h77;
      end
      #1;
      if (c == 4) begin
        n_checks++;
        if (mem_err !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b expected 0", mem_err); end
      end
      if (c == 5) begin
        n_checks++;
        if ({mem_err, dc.dREN, mem_stall} !== 3'b111) begin
          n_fail++; $display("FAIL tmo_raise: got %b expected 111", {mem_err, dc.dREN, mem_stall});
        end
      end
      if (c == 7) begin
        n_checks++;
        if ({wb_valid, wb_RegW, wb_wdat, mem_err} !== {1'b1, 1'b1, 32'h77, 1'b1}) begin
          n_fail++; $display("FAIL tmo_complete: got %b%b/%h/%b expected 11/00000077/1", wb_valid, wb_RegW, wb_wdat, mem_err);
        end
      end
      step();
    end
  endtask

  task automatic test_reset_wait();
    pulse_reset();
    ex_valid = 1'b1; ex_dREN = 1'b1; ex_addr = 32'h300; ex_RegW = 1'b1; ex_npc = 32'h8;
    #1;
    step();
    bubble();
    #1;
    n_checks++;
    if (dc.dREN !== 1'b1) begin n_fail++; $display("FAIL rstw_req: got %b expected 1", dc.dREN); end
    nRST = 1'b0;
    #1;
    n_checks++;
    if ({dc.dREN, dc.dWEN, mem_stall, wb_valid, wb_halt, mem_err} !== 6'b0) begin
      n_fail++; $display("FAIL rstw_ctrl: got %b expected 000000", {dc.dREN, dc.dWEN, mem_stall, wb_valid, wb_halt, mem_err});
    end
    n_checks++;
    if ({dc.daddr, wb_npc, wb_wdat} !== 96'd0) begin
      n_fail++; $display("FAIL rstw_data: got %h %h %h expected 0", dc.daddr, wb_npc, wb_wdat);
    end
    @(negedge CLK);
    nRST = 1'b1;
    step();
    n_checks++;
    if ({dc.dREN, mem_stall} !== 2'b00) begin n_fail++; $display("FAIL rstw_idle: got %b expected 00", {dc.dREN, mem_stall}); end
  endtask

  task automatic test_halt();
    int wen_n = 0;
    ex_valid = 1'b1; ex_halt = 1'b1; ex_dWEN = 1'b1; ex_addr = 32'h40; ex_npc = 32'hC;
    #1;
    n_checks++;
    if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL halt_accept_stall: got %b expected 0", mem_stall); end
    step();
    for (int c = 0; c < 4; c++) begin
      bubble();
      ex_valid = 1'b1; ex_dWEN = 1'b1; ex_addr = 32'h40; ex_store = 32'h99;
      #1;
      wen_n += int'(dc.dWEN);
      n_checks++;
      if ({wb_halt, mem_stall} !== 2'b11) begin n_fail++; $display("FAIL halt_sticky c%0d: got %b expected 11", c, {wb_halt, mem_stall}); end
      if (c > 0) begin
        n_checks++;
        if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL halt_valid c%0d: got %b expected 0", c, wb_valid); end
      end
      step();
    end
    n_checks++;
    if (wen_n != 0) begin n_fail++; $display("FAIL halt_no_dwen: got %0d expected 0", wen_n); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_alu();
    test_load_miss();
    test_store_hit();
    test_misaligned();
    test_timeout();
    test_reset_wait();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
